// File: rtl/cpu_sequencer_pkg.sv
// Shared constants for the CPU instruction-cycle sequencer: widths, opcodes, state encoding.
package cpu_pkg;

  localparam int ADDR_W = 5;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_HLT = 3'd0;
  localparam logic [OP_W-1:0] OP_SKZ = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD = 3'd2;
  localparam logic [OP_W-1:0] OP_AND = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_LDA = 3'd5;
  localparam logic [OP_W-1:0] OP_STO = 3'd6;
  localparam logic [OP_W-1:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    F_HI   = 3'd0,
    F_LO   = 3'd1,
    DECODE = 3'd2,
    EX1    = 3'd3,
    EX2    = 3'd4,
    EX3    = 3'd5,
    HALTED = 3'd6
  } state_t;

  // Opcodes that read memory into the accumulator.
  function automatic logic is_mem_read(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/strobe bundle between the sequencer and the CPU datapath.
// Carries the step input only when SINGLE_STEP_EN is defined.
interface cpu_sequencer_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int OP_W   = cpu_pkg::OP_W
);
  logic              ena;
  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] ir_addr;
  logic              zero;
`ifdef SINGLE_STEP_EN
  logic              step;
`endif
  logic              inc_pc;
  logic              load_pc;
  logic [ADDR_W-1:0] pc_data;
  logic              rd;
  logic              wr;
  logic              load_ir;
  logic              load_acc;
  logic              datactl_ena;
  logic              halt;

`ifdef SINGLE_STEP_EN
  modport master (output ena, opcode, ir_addr, zero, step,
                  input  inc_pc, load_pc, pc_data, rd, wr, load_ir, load_acc, datactl_ena, halt);
  modport slave  (input  ena, opcode, ir_addr, zero, step,
                  output inc_pc, load_pc, pc_data, rd, wr, load_ir, load_acc, datactl_ena, halt);
`else
  modport master (output ena, opcode, ir_addr, zero,
                  input  inc_pc, load_pc, pc_data, rd, wr, load_ir, load_acc, datactl_ena, halt);
  modport slave  (input  ena, opcode, ir_addr, zero,
                  output inc_pc, load_pc, pc_data, rd, wr, load_ir, load_acc, datactl_ena, halt);
`endif
endinterface

// File: rtl/cpu_seq_decode.sv
// Strobe table: combinational decode of (state, latched opcode, zero) onto the datapath controls.
module cpu_seq_decode
  import cpu_pkg::*;
(
  input  state_t          i_state,
  input  logic [OP_W-1:0] i_op,
  input  logic            i_start,
  cpu_sequencer_if.slave  bus
);

  always_comb begin
    bus.inc_pc      = 1'b0;
    bus.load_pc     = 1'b0;
    bus.pc_data     = '0;
    bus.rd          = 1'b0;
    bus.wr          = 1'b0;
    bus.load_ir     = 1'b0;
    bus.load_acc    = 1'b0;
    bus.datactl_ena = 1'b0;
    bus.halt        = 1'b0;
    case (i_state)
      F_HI, F_LO: begin
        if (i_state == F_LO || i_start) begin
          bus.rd      = 1'b1;
          bus.load_ir = 1'b1;
          bus.inc_pc  = 1'b1;
        end
      end
      EX1: begin
        if (is_mem_read(i_op)) bus.rd = 1'b1;
        if (i_op == OP_STO)    bus.datactl_ena = 1'b1;
      end
      EX2: begin
        if (is_mem_read(i_op)) begin
          bus.rd       = 1'b1;
          bus.load_acc = 1'b1;
        end
        if (i_op == OP_STO) begin
          bus.wr          = 1'b1;
          bus.datactl_ena = 1'b1;
        end
        if (i_op == OP_JMP) begin
          bus.load_pc = 1'b1;
          bus.pc_data = bus.ir_addr;
        end
        if (i_op == OP_SKZ) bus.inc_pc = bus.zero;
      end
      EX3: begin
        // STO keeps the bus driven one cycle past the write strobe.
        if (i_op == OP_SKZ) bus.inc_pc = bus.zero;
        if (i_op == OP_STO) bus.datactl_ena = 1'b1;
      end
      HALTED:  bus.halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Six-cycle instruction sequencer (fetch hi, fetch lo, decode, three execute cycles).
// Optional macro SINGLE_STEP_EN: fetch needs ena & step, and step releases HALTED.
//
// state  | meaning
// F_HI   | idle / first instruction byte fetch when started
// F_LO   | second instruction byte fetch
// DECODE | opcode latched into op_q on exit
// EX1    | operand read / bus drive setup
// EX2    | accumulator load, write, jump or first skip increment
// EX3    | second skip increment / bus hold
// HALTED | halt asserted, waits for reset (or step)
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_,
  cpu_sequencer_if.slave bus
);

  state_t          r_state;
  state_t          w_next_state;
  logic [OP_W-1:0] r_op_q;
  logic [OP_W-1:0] w_next_op;
  logic            w_start;
  logic            w_step;

`ifdef SINGLE_STEP_EN
  assign w_step = bus.step;
`else
  assign w_step = 1'b1;
`endif

  // rst_ gates the start so the combinational fetch strobes are dead during reset.
  assign w_start = bus.ena & w_step & rst_;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= F_HI;
      r_op_q  <= '0;
    end else begin
      r_state <= w_next_state;
      r_op_q  <= w_next_op;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_op    = r_op_q;
    case (r_state)
      F_HI:   if (w_start) w_next_state = F_LO;
      F_LO:   w_next_state = DECODE;
      DECODE: begin
        w_next_op    = bus.opcode;
        w_next_state = (bus.opcode == OP_HLT) ? HALTED : EX1;
      end
      EX1:    w_next_state = EX2;
      EX2:    w_next_state = EX3;
      EX3:    w_next_state = F_HI;
      HALTED: begin
        if (w_step == 1'b1 && r_state == HALTED) begin
`ifdef SINGLE_STEP_EN
          w_next_state = F_HI;
          w_next_op    = '0;
`endif
        end
      end
      default: w_next_state = F_HI;
    endcase
  end

  cpu_seq_decode u_decode (
    .i_state (r_state),
    .i_op    (r_op_q),
    .i_start (w_start),
    .bus     (bus)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed cycle table, hand sequences for reset/halt, random run vs. model.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  cpu_sequencer_if bus ();
  cpu_sequencer dut (.clk(clk), .rst_(rst_), .bus(bus));

  logic step_v;
`ifdef SINGLE_STEP_EN
  assign bus.step = step_v;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // {inc_pc, load_pc, pc_data[4:0], rd, wr, load_ir, load_acc, datactl_ena, halt}
  typedef logic [12:0] obs_t;

  function automatic obs_t mk(bit inc, bit ld, logic [4:0] pcd, bit rd, bit wr,
                              bit ir, bit acc, bit dce, bit hlt);
    return {inc, ld, pcd, rd, wr, ir, acc, dce, hlt};
  endfunction

  function automatic obs_t sample();
    return {bus.inc_pc, bus.load_pc, bus.pc_data, bus.rd, bus.wr,
            bus.load_ir, bus.load_acc, bus.datactl_ena, bus.halt};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (inc,ld,pcd5,rd,wr,ir,acc,dce,halt)", name, got, exp);
    end
  endtask

  task automatic drive(input bit ena, input logic [2:0] op, input logic [4:0] addr, input bit z);
    bus.ena     = ena;
    bus.opcode  = op;
    bus.ir_addr = addr;
    bus.zero    = z;
  endtask

  typedef struct {
    bit         ena;
    logic [2:0] op;
    logic [4:0] addr;
    bit         zero;
    obs_t       exp;
    string      name;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit ena, input logic [2:0] op, input logic [4:0] addr, input bit z,
                     input obs_t exp, input string name);
    vec_t v;
    v.ena = ena; v.op = op; v.addr = addr; v.zero = z; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  // Reference model: position within the 6-cycle instruction plus a halted flag.
  int         m_cnt;
  bit         m_halted;
  logic [2:0] m_op;

  function automatic obs_t model_out(bit go, bit z, logic [4:0] a);
    obs_t f, n;
    bit alu;
    f   = mk(1,0,0,1,0,1,0,0,0);
    n   = '0;
    alu = (m_op >= 3'd2) && (m_op <= 3'd5);
    if (m_halted) return mk(0,0,0,0,0,0,0,0,1);
    case (m_cnt)
      0: return go ? f : n;
      1: return f;
      3: if (alu) return mk(0,0,0,1,0,0,0,0,0);
         else if (m_op == 3'd6) return mk(0,0,0,0,0,0,0,1,0);
      4: if (alu) return mk(0,0,0,1,0,0,1,0,0);
         else if (m_op == 3'd6) return mk(0,0,0,0,1,0,0,1,0);
         else if (m_op == 3'd7) return mk(0,1,a,0,0,0,0,0,0);
         else if (m_op == 3'd1) return mk(z,0,0,0,0,0,0,0,0);
      5: if (m_op == 3'd1) return mk(z,0,0,0,0,0,0,0,0);
         else if (m_op == 3'd6) return mk(0,0,0,0,0,0,0,1,0);
      default: ;
    endcase
    return n;
  endfunction

  task automatic model_clk(bit go, logic [2:0] opc);
    if (m_halted) begin
`ifdef SINGLE_STEP_EN
      if (step_v) begin m_halted = 0; m_op = 0; end
`endif
    end else if (m_cnt == 0) begin
      if (go) m_cnt = 1;
    end else if (m_cnt == 2) begin
      m_op = opc;
      if (opc == 3'd0) begin m_halted = 1; m_cnt = 0; end
      else m_cnt = 3;
    end else begin
      m_cnt = (m_cnt + 1) % 6;
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_halted = 0; m_op = 0;
  endtask

  obs_t F, N;
  int   halt_cycles;

  initial begin
    F = mk(1,0,0,1,0,1,0,0,0);
    N = '0;
    step_v = 1'b1;

    // idle, then ADD/JMP/SKZ(z=1)/SKZ(z=0)/STO back to back
    add(0, OP_ADD, 5'h00, 0, N, "idle0");
    add(0, OP_ADD, 5'h00, 0, N, "idle1");
    add(1, OP_ADD, 5'h03, 0, F, "add_c1");
    add(1, OP_ADD, 5'h03, 0, F, "add_c2");
    add(1, OP_ADD, 5'h03, 0, N, "add_c3");
    add(1, OP_ADD, 5'h03, 0, mk(0,0,0,1,0,0,0,0,0), "add_c4");
    add(1, OP_ADD, 5'h03, 0, mk(0,0,0,1,0,0,1,0,0), "add_c5");
    add(1, OP_ADD, 5'h03, 0, N, "add_c6");
    add(1, OP_JMP, 5'h1A, 1, F, "jmp_c1");
    add(1, OP_JMP, 5'h1A, 1, F, "jmp_c2");
    add(1, OP_JMP, 5'h1A, 1, N, "jmp_c3");
    add(1, OP_JMP, 5'h1A, 1, N, "jmp_c4");
    add(1, OP_JMP, 5'h1A, 1, mk(0,1,5'h1A,0,0,0,0,0,0), "jmp_c5");
    add(1, OP_JMP, 5'h1A, 1, N, "jmp_c6");
    add(1, OP_SKZ, 5'h05, 1, F, "skz1_c1");
    add(1, OP_SKZ, 5'h05, 1, F, "skz1_c2");
    add(1, OP_SKZ, 5'h05, 1, N, "skz1_c3");
    add(1, OP_SKZ, 5'h05, 1, N, "skz1_c4");
    add(1, OP_SKZ, 5'h05, 1, mk(1,0,0,0,0,0,0,0,0), "skz1_c5");
    add(1, OP_SKZ, 5'h05, 1, mk(1,0,0,0,0,0,0,0,0), "skz1_c6");
    add(1, OP_SKZ, 5'h05, 0, F, "skz0_c1");
    add(1, OP_SKZ, 5'h05, 0, F, "skz0_c2");
    add(1, OP_SKZ, 5'h05, 0, N, "skz0_c3");
    add(1, OP_SKZ, 5'h05, 0, N, "skz0_c4");
    add(1, OP_SKZ, 5'h05, 0, N, "skz0_c5");
    add(1, OP_SKZ, 5'h05, 0, N, "skz0_c6");
    add(1, OP_STO, 5'h11, 0, F, "sto_c1");
    add(1, OP_STO, 5'h11, 0, F, "sto_c2");
    add(1, OP_STO, 5'h11, 0, N, "sto_c3");
    add(1, OP_STO, 5'h11, 0, mk(0,0,0,0,0,0,0,1,0), "sto_c4");
    add(1, OP_STO, 5'h11, 0, mk(0,0,0,0,1,0,0,1,0), "sto_c5");
    add(0, OP_STO, 5'h11, 0, mk(0,0,0,0,0,0,0,1,0), "sto_c6");

    // reset held with ena=1: nothing may strobe
    rst_ = 1'b0;
    drive(1, OP_STO, 5'h1F, 1);
    repeat (3) begin
      @(negedge clk); #1;
      check("reset_hold", sample(), N);
    end
    @(negedge clk);
    rst_ = 1'b1;
    drive(0, OP_ADD, 5'h00, 0);
    repeat (5) begin
      @(negedge clk); #1;
      check("idle_after_reset", sample(), N);
    end

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].ena, tbl[i].op, tbl[i].addr, tbl[i].zero);
      #1;
      check(tbl[i].name, sample(), tbl[i].exp);
    end

    // asynchronous reset in the middle of STO EX2
    @(negedge clk);
    drive(1, OP_STO, 5'h04, 0);
    repeat (4) @(negedge clk);
    #1;
    check("sto_ex2_before_rst", sample(), mk(0,0,0,0,1,0,0,1,0));
    #2 rst_ = 1'b0;
    #1;
    check("sto_async_rst", sample(), N);
    @(negedge clk);
    #1;
    check("sto_rst_held", sample(), N);
    rst_ = 1'b1;
    drive(0, OP_ADD, 5'h00, 0);

    // HLT: halted from cycle 4, absorbing
    @(negedge clk);
    drive(1, OP_HLT, 5'h09, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("hlt_decode", sample(), N);
`ifdef SINGLE_STEP_EN
    step_v = 1'b0;
`endif
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 1), 3'($urandom_range(1, 7)), 5'($urandom), $urandom_range(0, 1));
      #1;
      check("hlt_hold", sample(), mk(0,0,0,0,0,0,0,0,1));
    end
`ifdef SINGLE_STEP_EN
    @(negedge clk);
    drive(1, OP_ADD, 5'h00, 0);
    step_v = 1'b1;
    #1;
    check("step_in_halt", sample(), mk(0,0,0,0,0,0,0,0,1));
    @(negedge clk);
    step_v = 1'b0;
    #1;
    check("step_released", sample(), N);
    @(negedge clk);
    step_v = 1'b1;
    #1;
    check("step_fetch", sample(), F);
`endif

    // random run against the model, with occasional resets
    @(negedge clk);
    rst_ = 1'b0;
    model_reset();
    halt_cycles = 0;
    for (int c = 0; c < 1500; c++) begin
      bit do_rst;
      @(negedge clk);
      rst_ = 1'b1;
      drive($urandom_range(0, 3) != 0, 3'($urandom), 5'($urandom), $urandom_range(0, 1));
`ifdef SINGLE_STEP_EN
      step_v = $urandom_range(0, 1);
`endif
      do_rst = ($urandom_range(0, 99) == 0) || (halt_cycles > 3);
      if (do_rst) begin
        rst_ = 1'b0;
        #1;
        check("rand_reset", sample(), N);
        model_reset();
        halt_cycles = 0;
        @(posedge clk);
      end else begin
        #1;
        check("rand", sample(), model_out(bus.ena & step_v, bus.zero, bus.ir_addr));
        @(posedge clk);
        model_clk(bus.ena & step_v, bus.opcode);
        halt_cycles = m_halted ? halt_cycles + 1 : 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
